fir_tap_sequencer: RTL

//  Time-multiplexed controller for the shift-add clap FIR: one shared shift/add unit

---
 rtl/fir_tap_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fir_tap_sequencer.sv
// Serial shift-add FIR controller: one shared adder evaluates five taps, one tap per clock.
// Define FIR_CLAP_DETECT_EN to build the thresholded clap detector with re-arm holdoff.
module fir_tap_sequencer #(
  parameter int unsigned DW      = 8,
  parameter int unsigned OW      = 10,
  parameter int unsigned SH0     = 5,
  parameter int unsigned SH1     = 4,
  parameter int unsigned SH2     = 3,
  parameter int unsigned SH3     = 2,
  parameter int unsigned SH4     = 1,
  parameter int unsigned THRESH  = 100,
  parameter int unsigned HOLDOFF = 1000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] x,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] dout,
  output logic          primed,
  output logic          clap
);

  typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

  state_e        r_state, w_state_d;
  logic [DW-1:0] r_hist [5];
  logic [OW-1:0] r_acc, r_dout, w_sum;
  logic [DW-1:0] w_shifted;
  logic [2:0]    r_idx, r_cnt, w_cnt_d;
  logic          r_primed;
  logic          w_accept, w_flush, w_out_hs, w_last_tap;

  // Flush outranks a simultaneous sample offer; both only matter in IDLE.
  assign w_flush    = (r_state == StIdle) && flush;
  assign w_accept   = (r_state == StIdle) && in_valid && !flush;
  assign w_out_hs   = (r_state == StHold) && out_ready;
  assign w_last_tap = (r_idx == 3'd4);

  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StHold);
  assign dout      = r_dout;
  assign primed    = r_primed;

  always_comb begin
    w_shifted = r_hist[0] >> SH0;
    case (r_idx)
      3'd1:    w_shifted = r_hist[1] >> SH1;
      3'd2:    w_shifted = r_hist[2] >> SH2;
      3'd3:    w_shifted = r_hist[3] >> SH3;
      3'd4:    w_shifted = r_hist[4] >> SH4;
      default: w_shifted = r_hist[0] >> SH0;
    endcase
  end

  assign w_sum = r_acc + OW'(w_shifted);

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (w_accept) w_state_d = StAcc;
      StAcc:   if (w_last_tap) w_state_d = StHold;
      StHold:  if (w_out_hs) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_cnt_d = r_cnt;
    if (w_flush) begin
      w_cnt_d = '0;
    end else if (w_accept && (r_cnt != 3'd5)) begin
      w_cnt_d = r_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_acc    <= '0;
      r_dout   <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_primed <= 1'b0;
      for (int k = 0; k < 5; k++) r_hist[k] <= '0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_primed <= (w_cnt_d == 3'd5);
      if (w_flush) begin
        for (int k = 0; k < 5; k++) r_hist[k] <= '0;
      end else if (w_accept) begin
        r_hist[0] <= x;
        for (int k = 1; k < 5; k++) r_hist[k] <= r_hist[k-1];
        r_acc <= '0;
        r_idx <= '0;
      end
      if (r_state == StAcc) begin
        r_acc <= w_sum;
        r_idx <= r_idx + 3'd1;
        if (w_last_tap) r_dout <= w_sum;
      end
    end
  end

`ifdef FIR_CLAP_DETECT_EN
  localparam int unsigned HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  logic [HW-1:0] r_holdoff;
  logic          r_clap;
  logic          w_fire;

  // Result is judged at its handshake, so the pulse lands in the cycle after.
  assign w_fire = w_out_hs && r_primed && (r_dout >= OW'(THRESH)) && (r_holdoff == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_holdoff <= '0;
      r_clap    <= 1'b0;
    end else begin
      r_clap <= w_fire;
      if (w_flush) begin
        r_holdoff <= '0;
      end else if (w_fire) begin
        r_holdoff <= HW'(HOLDOFF);
      end else if (r_holdoff != '0) begin
        r_holdoff <= r_holdoff - 1'b1;
      end
    end
  end

  assign clap = r_clap;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{THRESH, HOLDOFF};
  assign clap         = 1'b0;
`endif

endmodule
